// File: rtl/q2_panel_ctrl_if.sv
// Front-panel bundle for q2_panel_ctrl: raw switches and core halt in, core controls out.
// The controller connects through the slave modport; the panel/core side uses master.
interface q2_panel_ctrl_if;
  logic start_sw;
  logic stop_sw;
  logic dep_sw;
  logic incp_sw;
  logic halt;
  logic run;
  logic dep;
  logic incp;
  logic busy;
  logic halted;

  modport master (
    output start_sw, stop_sw, dep_sw, incp_sw, halt,
    input  run, dep, incp, busy, halted
  );

  modport slave (
    input  start_sw, stop_sw, dep_sw, incp_sw, halt,
    output run, dep, incp, busy, halted
  );
endinterface

// File: rtl/q2_panel_ctrl.sv
// q2 front-panel sequencer: synchronise/debounce panel switches, arbitrate, drive run/dep/incp.
// Optional macro Q2_PANEL_AUTOINC_EN: a completed deposit chains directly into an increment-P.
module q2_panel_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int DEP_HOLD        = 4,
  parameter int INCP_HOLD       = 2
) (
  input  logic           clk,
  input  logic           rst,
  q2_panel_ctrl_if.slave pnl
);

  localparam int NSW      = 4;
  localparam int SW_START = 0;
  localparam int SW_STOP  = 1;
  localparam int SW_DEP   = 2;
  localparam int SW_INCP  = 3;

  localparam int                DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0]   DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  localparam int                MAX_HOLD  = (DEP_HOLD > INCP_HOLD) ? DEP_HOLD : INCP_HOLD;
  localparam int                HOLD_W    = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] DEP_LOAD  = HOLD_W'(DEP_HOLD);
  localparam logic [HOLD_W-1:0] INCP_LOAD = HOLD_W'(INCP_HOLD);

  // S_GAP is the single idle cycle between the chained deposit and increment phases.
  typedef enum logic [2:0] {
    S_STOP = 3'd0,
    S_RUN  = 3'd1,
    S_DEP  = 3'd2,
    S_GAP  = 3'd3,
    S_INCP = 3'd4
  } state_t;

  // ---------------------------------------------------------------------------
  // Switch input path: 2-flop synchroniser, debounce counter, rising-edge event
  // ---------------------------------------------------------------------------
  logic [NSW-1:0]  raw_sw;
  logic [NSW-1:0]  sync_a;
  logic [NSW-1:0]  sync_b;
  logic [NSW-1:0]  db_lvl;
  logic [NSW-1:0]  sw_ev;
  logic [DB_W-1:0] db_cnt [NSW];

  assign raw_sw = {pnl.incp_sw, pnl.dep_sw, pnl.stop_sw, pnl.start_sw};

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a <= '0;
      sync_b <= '0;
      // Debounced levels start high so a switch held through reset yields no event.
      db_lvl <= '1;
      sw_ev  <= '0;
      // NOTE: db_cnt is a small flop array, not a RAM, so it is safe to reset it here.
      for (int i = 0; i < NSW; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync_a <= raw_sw;
      sync_b <= sync_a;
      for (int i = 0; i < NSW; i++) begin
        sw_ev[i] <= 1'b0;
        if (sync_b[i] == db_lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_lvl[i] <= sync_b[i];
          db_cnt[i] <= '0;
          sw_ev[i]  <= sync_b[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  logic start_ev;
  logic stop_ev;
  logic dep_ev;
  logic incp_ev;

  assign start_ev = sw_ev[SW_START];
  assign stop_ev  = sw_ev[SW_STOP];
  assign dep_ev   = sw_ev[SW_DEP];
  assign incp_ev  = sw_ev[SW_INCP];

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  state_t            state;
  state_t            state_next;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_next;
  logic              halt_q;
  logic              halt_rise;
  logic              halted_q;
  logic              halted_next;
  logic              run_q;
  logic              dep_q;
  logic              incp_q;
  logic              busy_q;

  // Only a fresh halt edge ends a run, so a start issued while halt is high sticks.
  assign halt_rise = pnl.halt & ~halt_q;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_next  = state;
    hold_next   = hold_cnt;
    halted_next = halted_q;

    case (state)
      S_STOP: begin
        // stop > start > dep > incp; a stop event here simply swallows the rest.
        if (!stop_ev) begin
          if (start_ev) begin
            state_next  = S_RUN;
            halted_next = 1'b0;
          end else if (dep_ev) begin
            state_next = S_DEP;
            hold_next  = DEP_LOAD;
          end else if (incp_ev) begin
            state_next = S_INCP;
            hold_next  = INCP_LOAD;
          end
        end
      end

      S_RUN: begin
        if (stop_ev) begin
          state_next = S_STOP;
        end else if (halt_rise) begin
          state_next  = S_STOP;
          halted_next = 1'b1;
        end
      end

      S_DEP: begin
        if (hold_cnt == HOLD_W'(1)) begin
`ifdef Q2_PANEL_AUTOINC_EN
          state_next = S_GAP;
`else
          state_next = S_STOP;
`endif
        end else begin
          hold_next = hold_cnt - 1'b1;
        end
      end

      S_GAP: begin
        state_next = S_INCP;
        hold_next  = INCP_LOAD;
      end

      S_INCP: begin
        if (hold_cnt == HOLD_W'(1)) begin
          state_next = S_STOP;
        end else begin
          hold_next = hold_cnt - 1'b1;
        end
      end

      default: begin
        state_next = S_STOP;
        hold_next  = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state into flops so they align with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_STOP;
      hold_cnt <= '0;
      halt_q   <= 1'b0;
      halted_q <= 1'b0;
      run_q    <= 1'b0;
      dep_q    <= 1'b0;
      incp_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_next;
      hold_cnt <= hold_next;
      halt_q   <= pnl.halt;
      halted_q <= halted_next;
      run_q    <= (state_next == S_RUN);
      dep_q    <= (state_next == S_DEP);
      incp_q   <= (state_next == S_INCP);
      busy_q   <= (state_next == S_DEP) || (state_next == S_GAP) || (state_next == S_INCP);
    end
  end

  assign pnl.run    = run_q;
  assign pnl.dep    = dep_q;
  assign pnl.incp   = incp_q;
  assign pnl.busy   = busy_q;
  assign pnl.halted = halted_q;

endmodule
